// File: rtl/clk_div_sched.sv
// Programmable clock divider. Ratio changes and start/stop are applied only at
// period boundaries, so clk_out never shows a runt or a glitch.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [CNT_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] div_active_r, div_active_s;
  logic [CNT_W-1:0] pend_r, pend_s;
  logic             pend_valid_r, pend_valid_s;
  logic             ack_r, ack_s;
  logic             clk_out_r, clk_out_s;
  logic             tick_r, tick_s;
  logic             err_r, err_s;

  logic             xfer_s, legal_s, wrap_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W:0]   half_s;

  // ack_r holds div_ready low for the one cycle after an IDLE write, which is applied immediately
  assign div_ready  = ~(pend_valid_r | ack_r);
  assign div_active = div_active_r;
  assign clk_out    = clk_out_r;
  assign tick       = tick_r;
  assign busy       = (state_r == S_RUN);
  assign err        = err_r;

  assign xfer_s    = div_valid & div_ready;
  assign legal_s   = (div_in >= TWO);
  assign wrap_s    = (state_r == S_RUN) && (cnt_r == (div_active_r - ONE));
  assign cnt_inc_s = cnt_r + ONE;
  assign half_s    = ({1'b0, div_active_r} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

  // Next-state, counter and ratio-handshake logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    div_active_s = div_active_r;
    pend_s       = pend_r;
    pend_valid_s = pend_valid_r;
    ack_s        = 1'b0;
    clk_out_s    = 1'b0;
    tick_s       = 1'b0;
    err_s        = xfer_s & ~legal_s;

    case (state_r)
      S_IDLE: begin
        cnt_s = ZERO;
        if (xfer_s && legal_s) begin
          div_active_s = div_in;
          ack_s        = 1'b1;
        end else begin
          div_active_s = div_active_r;
        end
        if (en) begin
          state_s   = S_RUN;
          clk_out_s = 1'b1;
          tick_s    = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (wrap_s) begin
          cnt_s = ZERO;
          if (pend_valid_r) begin
            div_active_s = pend_r;
            pend_valid_s = 1'b0;
          end else begin
            div_active_s = div_active_r;
          end
          if (en) begin
            clk_out_s = 1'b1;
            tick_s    = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s     = cnt_inc_s;
          clk_out_s = ({1'b0, cnt_inc_s} < half_s);
        end
        // a write landing on the wrap edge is only captured here, so it waits a full period
        if (xfer_s && legal_s) begin
          pend_s       = div_in;
          pend_valid_s = 1'b1;
        end else begin
          pend_s = pend_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = ZERO;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= ZERO;
      div_active_r <= DEF_N;
      pend_r       <= ZERO;
      pend_valid_r <= 1'b0;
      ack_r        <= 1'b0;
      clk_out_r    <= 1'b0;
      tick_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      div_active_r <= div_active_s;
      pend_r       <= pend_s;
      pend_valid_r <= pend_valid_s;
      ack_r        <= ack_s;
      clk_out_r    <= clk_out_s;
      tick_r       <= tick_s;
      err_r        <= err_s;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: a vector table for cycle-by-cycle behaviour
// plus hand sequences for the full-width ratio and asynchronous reset.
module tb_clk_div_sched;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic [7:0] div_active;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       dv;
    logic [7:0] din;
    logic       clk;
    logic       tck;
    logic       bsy;
    logic       rdy;
    logic [7:0] act;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  clk_div_sched #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_active(div_active),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", nm, row, got, want);
    end
  endtask

  task automatic chk_all(input int row, input logic c, input logic t, input logic b,
                         input logic r, input logic [7:0] a, input logic e);
    chk("clk_out", row, {31'd0, clk_out}, {31'd0, c});
    chk("tick", row, {31'd0, tick}, {31'd0, t});
    chk("busy", row, {31'd0, busy}, {31'd0, b});
    chk("div_ready", row, {31'd0, div_ready}, {31'd0, r});
    chk("div_active", row, {24'd0, div_active}, {24'd0, a});
    chk("err", row, {31'd0, err}, {31'd0, e});
  endtask

  function automatic void add(input logic e, input logic dv, input logic [7:0] din,
                              input logic c, input logic t, input logic b,
                              input logic r, input logic [7:0] a, input logic er);
    vec_t v;
    v.en = e; v.dv = dv; v.din = din; v.clk = c; v.tck = t;
    v.bsy = b; v.rdy = r; v.act = a; v.er = er;
    vecs.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic e, input logic dv, input logic [7:0] din);
    en = e; div_valid = dv; div_in = din;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    int hi;
    rst = 1'b0; en = 1'b0; div_valid = 1'b0; div_in = 8'd0;

    //   en dv din   clk tck bsy rdy act er
    // N=3 run, then en dropped at cnt=0: period completes
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    // IDLE write of 4, then run N=4
    add(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    // illegal ratios 1 and 0
    add(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    add(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    // RUN write of 5, applied at wrap
    add(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0);
    // N=5 write of 2 at cnt=1: period stays 1,1,1,0,0
    add(1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
    // write on the wrap edge waits one more period
    add(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    // en glitch before the wrap has no effect
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    // pending apply and stop at the same wrap
    add(1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
    // write and en rising together in IDLE: starts with N=2
    add(1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);

    repeat (2) @(negedge clk_in);
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].dv, vecs[i].din);
      chk_all(i, vecs[i].clk, vecs[i].tck, vecs[i].bsy, vecs[i].rdy, vecs[i].act, vecs[i].er);
    end

    // stop, then run with the largest ratio: 128 of 255 cycles high
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("stop_busy", 100, {31'd0, busy}, 32'd0);
    step(1'b1, 1'b1, 8'd255);
    chk("n255_act", 101, {24'd0, div_active}, 32'd255);
    hi = (clk_out === 1'b1) ? 1 : 0;
    for (int k = 0; k < 254; k++) begin
      step(1'b1, 1'b0, 8'd0);
      if (clk_out === 1'b1) hi++;
    end
    chk("n255_high", 102, hi, 32'd128);
    step(1'b1, 1'b0, 8'd0);
    chk("n255_tick", 103, {31'd0, tick}, 32'd1);
    for (int k = 0; k < 99; k++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd9);
    chk("cnt100_clk", 104, {31'd0, clk_out}, 32'd1);
    chk("cnt100_rdy", 105, {31'd0, div_ready}, 32'd0);

    // asynchronous reset mid-period takes effect without a clock edge
    rst = 1'b0;
    #1;
    chk_all(106, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    @(negedge clk_in);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    chk_all(107, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b1, 1'b0, 8'd0);
    chk("post_rst_clk0", 108, {31'd0, clk_out}, 32'd1);
    step(1'b1, 1'b0, 8'd0);
    chk("post_rst_clk1", 109, {31'd0, clk_out}, 32'd1);
    step(1'b1, 1'b0, 8'd0);
    chk("post_rst_clk2", 110, {31'd0, clk_out}, 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("post_rst_tick", 111, {31'd0, tick}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
